// File: rtl/matrix_collector.sv
// ----------------------------------------------------------------------------
// matrix_collector
//
// Purpose:
//   Captures a complete set of SQRT_P x SQRT_P block results (each BLK x BLK
//   32-bit words) in one cycle. It then streams the assembled N x N matrix out
//   in row-major order over a valid/ready handshake.
//
// Parameters:
//   N       full result matrix dimension
//   SQRT_P  processor grid dimension; BLK = N/SQRT_P words per block side
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   in_blocks       flattened block results; block (bi,bj) is at slot
//                   bi*SQRT_P+bj, and element (k,v) of a slot is at word
//                   offset k*BLK+v
//   in_valid        in_blocks holds a complete result set
//   in_ready        collector can accept a result set
//   out_data        current matrix element
//   out_row/out_col row/column of out_data
//   out_valid       out_data valid
//   out_ready       downstream accepts out_data
//   out_last        high with element (N-1,N-1)
//   checksum        running sum of transferred words (optional feature)
//   checksum_valid  one-cycle pulse when checksum is final
//
// Configuration macro:
//   COLLECT_CHECKSUM_EN  when defined, builds the checksum accumulator.
//                        Otherwise checksum and checksum_valid are tied to 0.
// ----------------------------------------------------------------------------
module matrix_collector #(
   parameter int N      = 4,
   parameter int SQRT_P = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [32*N*N-1:0]     in_blocks,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [31:0]           out_data,
   output logic [$clog2(N)-1:0]  out_row,
   output logic [$clog2(N)-1:0]  out_col,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic [31:0]           checksum,
   output logic                  checksum_valid
);

   localparam int BLK = N / SQRT_P;
   localparam int RW  = $clog2(N);
   localparam logic [RW-1:0] LAST_IDX = RW'(N - 1);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   // Word index inside in_blocks / r_buf of matrix element (r,c)
   function automatic int elem_word(input int r, input int c);
      return (((r / BLK) * SQRT_P + (c / BLK)) * BLK * BLK)
             + ((r % BLK) * BLK) + (c % BLK);
   endfunction

   state_t             r_state;
   state_t             w_next_state;
   logic [32*N*N-1:0]  r_buf;
   logic               r_in_ready;
   logic               r_out_valid;
   logic [31:0]        r_out_data;
   logic [RW-1:0]      r_out_row;
   logic [RW-1:0]      r_out_col;
   logic               r_out_last;

   logic               w_capture;
   logic               w_xfer;
   logic               w_done;
   logic [RW-1:0]      w_nxt_row;
   logic [RW-1:0]      w_nxt_col;
   logic               w_nxt_last;
   logic [31:0]        w_nxt_data;

   // in_ready is registered so it stays low while rst_n is asserted
   assign w_capture = (r_state == IDLE) & r_in_ready & in_valid;
   assign w_xfer    = r_out_valid & out_ready;
   assign w_done    = w_xfer & r_out_last;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_capture) begin
               w_next_state = STREAM;
            end else begin
               w_next_state = IDLE;
            end
         end
         STREAM: begin
            if (w_done) begin
               w_next_state = IDLE;
            end else begin
               w_next_state = STREAM;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Row-major successor of the current position and the element it selects
   always_comb begin
      w_nxt_row = r_out_row;
      w_nxt_col = r_out_col + RW'(1);
      if (r_out_col == LAST_IDX) begin
         w_nxt_col = '0;
         if (r_out_row == LAST_IDX) begin
            w_nxt_row = '0;
         end else begin
            w_nxt_row = r_out_row + RW'(1);
         end
      end else begin
         w_nxt_row = r_out_row;
      end
      w_nxt_last = (w_nxt_row == LAST_IDX) && (w_nxt_col == LAST_IDX);
      w_nxt_data = r_buf[32*elem_word(int'(w_nxt_row), int'(w_nxt_col)) +: 32];
   end

   // in_ready register; rises the cycle the FSM is back in IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_ready <= 1'b0;
      end else begin
         r_in_ready <= (w_next_state == IDLE);
      end
   end

   // Capture buffer and registered output stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= 32'd0;
         r_out_row   <= '0;
         r_out_col   <= '0;
         r_out_last  <= 1'b0;
      end else if (w_capture) begin
         r_buf       <= in_blocks;
         // element (0,0) is always word 0 of slot 0
         r_out_data  <= in_blocks[31:0];
         r_out_valid <= 1'b1;
         r_out_row   <= '0;
         r_out_col   <= '0;
         r_out_last  <= (N == 1);
      end else if (w_xfer) begin
         if (r_out_last) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
         end else begin
            r_out_row   <= w_nxt_row;
            r_out_col   <= w_nxt_col;
            r_out_data  <= w_nxt_data;
            r_out_last  <= w_nxt_last;
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_row   = r_out_row;
   assign out_col   = r_out_col;
   assign out_last  = r_out_last;

`ifdef COLLECT_CHECKSUM_EN
   logic [31:0] r_cs;
   logic        r_cs_valid;

   // Checksum accumulator; cleared on capture, final sum held until the next one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cs       <= 32'd0;
         r_cs_valid <= 1'b0;
      end else begin
         r_cs_valid <= w_done;
         if (w_capture) begin
            r_cs <= 32'd0;
         end else if (w_xfer) begin
            r_cs <= r_cs + r_out_data;
         end
      end
   end

   assign checksum       = r_cs;
   assign checksum_valid = r_cs_valid;
`else
   assign checksum       = 32'd0;
   assign checksum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_collector.sv
module tb_matrix_collector;

   localparam int N  = 4;
   localparam int N6 = 6;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [32*N*N-1:0] in_blocks;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       out_data;
   logic [1:0]        out_row, out_col;
   logic              out_valid, out_ready, out_last;
   logic [31:0]       checksum;
   logic              checksum_valid;

   logic [32*N6*N6-1:0] in_blocks6;
   logic                in_valid6, in_ready6;
   logic [31:0]         out_data6;
   logic [2:0]          out_row6, out_col6;
   logic                out_valid6, out_ready6, out_last6;
   logic [31:0]         checksum6;
   logic                checksum_valid6;

   int n_checks = 0;
   int n_fail   = 0;
   int exp4[16] = '{1, 2, 5, 6, 3, 4, 7, 8, 9, 10, 13, 14, 11, 12, 15, 16};

   always #5 clk = ~clk;

   matrix_collector #(.N(N), .SQRT_P(2)) dut (
      .clk(clk), .rst_n(rst_n), .in_blocks(in_blocks), .in_valid(in_valid),
      .in_ready(in_ready), .out_data(out_data), .out_row(out_row),
      .out_col(out_col), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .checksum(checksum), .checksum_valid(checksum_valid)
   );

   matrix_collector #(.N(N6), .SQRT_P(3)) dut6 (
      .clk(clk), .rst_n(rst_n), .in_blocks(in_blocks6), .in_valid(in_valid6),
      .in_ready(in_ready6), .out_data(out_data6), .out_row(out_row6),
      .out_col(out_col6), .out_valid(out_valid6), .out_ready(out_ready6),
      .out_last(out_last6), .checksum(checksum6), .checksum_valid(checksum_valid6)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load_ramp(input int base);
      for (int w = 0; w < 16; w++) in_blocks[32*w +: 32] = 32'(w + 1 + base);
   endtask

   task automatic capture;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL capture_ready: in_ready=%b expected 1", in_ready);
      end
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #2;
      n_checks++;
      if ({in_ready, out_valid, out_last, out_data, out_row, out_col, checksum, checksum_valid} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: rdy=%b vld=%b last=%b data=%h row=%0d col=%0d cs=%h csv=%b expected all 0",
                  in_ready, out_valid, out_last, out_data, out_row, out_col, checksum, checksum_valid);
      end
      tick();
      tick();
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_in_ready_low: in_ready=%b expected 0", in_ready);
      end
      rst_n = 1'b1;
      tick();
      n_checks++;
      if ({in_ready, out_valid, in_ready6} !== 3'b101) begin
         n_fail++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b in_ready6=%b expected 1,0,1",
                  in_ready, out_valid, in_ready6);
      end
   endtask

   task automatic test_stream;
      logic [31:0] exp_cs;
      logic        exp_csv;
      load_ramp(0);
      out_ready = 1'b1;
      capture();
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if ({out_valid, out_data, out_row, out_col, out_last} !==
             {1'b1, 32'(exp4[i]), 2'(i / 4), 2'(i % 4), (i == 15)}) begin
            n_fail++;
            $display("FAIL stream_elem[%0d]: vld=%b data=%0d row=%0d col=%0d last=%b expected 1 %0d %0d %0d %b",
                     i, out_valid, out_data, out_row, out_col, out_last, exp4[i], i / 4, i % 4, (i == 15));
         end
         tick();
      end
`ifdef COLLECT_CHECKSUM_EN
      exp_cs = 32'd136; exp_csv = 1'b1;
`else
      exp_cs = 32'd0;   exp_csv = 1'b0;
`endif
      n_checks++;
      if ({in_ready, out_valid, checksum_valid, checksum} !== {1'b1, 1'b0, exp_csv, exp_cs}) begin
         n_fail++;
         $display("FAIL stream_end: rdy=%b vld=%b csv=%b cs=%0d expected 1 0 %b %0d",
                  in_ready, out_valid, checksum_valid, checksum, exp_csv, exp_cs);
      end
      tick();
      n_checks++;
      if ({checksum_valid, checksum} !== {1'b0, exp_cs}) begin
         n_fail++;
         $display("FAIL checksum_pulse_hold: csv=%b cs=%0d expected 0 %0d", checksum_valid, checksum, exp_cs);
      end
   endtask

   task automatic test_stall;
      int          xfers;
      int          cyc;
      logic [36:0] prev;
      load_ramp(0);
      capture();
      xfers = 0;
      cyc   = 0;
      while (xfers < 16 && cyc < 100) begin
         out_ready = (cyc % 2 == 0);
         n_checks++;
         if ({out_valid, out_data, out_row, out_col, out_last} !==
             {1'b1, 32'(exp4[xfers]), 2'(xfers / 4), 2'(xfers % 4), (xfers == 15)}) begin
            n_fail++;
            $display("FAIL stall_elem[%0d]: vld=%b data=%0d row=%0d col=%0d last=%b expected data %0d",
                     xfers, out_valid, out_data, out_row, out_col, out_last, exp4[xfers]);
         end
         prev = {out_data, out_row, out_col, out_last};
         if (out_ready) xfers++;
         tick();
         if (!out_ready) begin
            n_checks++;
            if ({out_data, out_row, out_col, out_last} !== prev) begin
               n_fail++;
               $display("FAIL stall_stable[%0d]: now=%h before=%h", xfers, {out_data, out_row, out_col, out_last}, prev);
            end
         end
         cyc++;
      end
      out_ready = 1'b1;
      n_checks++;
      if (cyc !== 31 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_cycles: cycles=%0d out_valid=%b expected 31 0", cyc, out_valid);
      end
   endtask

   task automatic test_back_to_back;
      load_ramp(0);
      in_valid = 1'b1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_ready: in_ready=%b expected 1", in_ready);
      end
      tick();
      // in_valid stays high while the first set streams; a second set appears
      load_ramp(100);
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if ({in_ready, out_valid, out_data, out_row, out_col} !==
             {1'b0, 1'b1, 32'(exp4[i]), 2'(i / 4), 2'(i % 4)}) begin
            n_fail++;
            $display("FAIL b2b_first_set[%0d]: rdy=%b vld=%b data=%0d row=%0d col=%0d expected 0 1 %0d",
                     i, in_ready, out_valid, out_data, out_row, out_col, exp4[i]);
         end
         tick();
      end
      n_checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL b2b_gap: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
      end
      tick();
      in_valid = 1'b0;
      n_checks++;
      if ({out_valid, out_data, out_row, out_col} !== {1'b1, 32'd101, 2'd0, 2'd0}) begin
         n_fail++;
         $display("FAIL b2b_second_set: vld=%b data=%0d row=%0d col=%0d expected 1 101 0 0",
                  out_valid, out_data, out_row, out_col);
      end
      for (int i = 0; i < 40 && out_valid; i++) tick();
      tick();
   endtask

   task automatic test_reset_mid;
      logic [31:0] exp_cs;
      load_ramp(0);
      capture();
      for (int i = 0; i < 5; i++) tick();
      n_checks++;
      if ({out_data, out_row, out_col} !== {32'(exp4[5]), 2'd1, 2'd1}) begin
         n_fail++;
         $display("FAIL mid_before_reset: data=%0d row=%0d col=%0d expected %0d 1 1", out_data, out_row, out_col, exp4[5]);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({out_valid, in_ready, out_data, out_row, out_col, checksum_valid} !== '0) begin
         n_fail++;
         $display("FAIL mid_abort: vld=%b rdy=%b data=%0d row=%0d col=%0d csv=%b expected all 0",
                  out_valid, in_ready, out_data, out_row, out_col, checksum_valid);
      end
      tick();
      rst_n = 1'b1;
      tick();
      n_checks++;
      if ({in_ready, out_valid, checksum_valid} !== 3'b100) begin
         n_fail++;
         $display("FAIL mid_release: rdy=%b vld=%b csv=%b expected 1 0 0", in_ready, out_valid, checksum_valid);
      end
      load_ramp(200);
      capture();
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if ({out_valid, out_data, out_row, out_col} !== {1'b1, 32'(exp4[i] + 200), 2'(i / 4), 2'(i % 4)}) begin
            n_fail++;
            $display("FAIL mid_restart[%0d]: vld=%b data=%0d row=%0d col=%0d expected 1 %0d",
                     i, out_valid, out_data, out_row, out_col, exp4[i] + 200);
         end
         tick();
      end
`ifdef COLLECT_CHECKSUM_EN
      exp_cs = 32'd3336;
`else
      exp_cs = 32'd0;
`endif
      n_checks++;
      if (checksum !== exp_cs) begin
         n_fail++;
         $display("FAIL mid_checksum: cs=%0d expected %0d", checksum, exp_cs);
      end
      tick();
   endtask

   task automatic test_n6;
      logic [31:0] exp_cs;
      logic        exp_csv;
      in_blocks6 = '1;
      n_checks++;
      if (in_ready6 !== 1'b1) begin
         n_fail++;
         $display("FAIL n6_ready: in_ready6=%b expected 1", in_ready6);
      end
      in_valid6 = 1'b1;
      tick();
      in_valid6 = 1'b0;
      for (int i = 0; i < 36; i++) begin
         n_checks++;
         if ({out_valid6, out_data6, out_row6, out_col6, out_last6} !==
             {1'b1, 32'hFFFF_FFFF, 3'(i / 6), 3'(i % 6), (i == 35)}) begin
            n_fail++;
            $display("FAIL n6_elem[%0d]: vld=%b data=%h row=%0d col=%0d last=%b expected 1 ffffffff %0d %0d %b",
                     i, out_valid6, out_data6, out_row6, out_col6, out_last6, i / 6, i % 6, (i == 35));
         end
         tick();
      end
`ifdef COLLECT_CHECKSUM_EN
      exp_cs = 32'hFFFF_FFDC; exp_csv = 1'b1;
`else
      exp_cs = 32'd0;         exp_csv = 1'b0;
`endif
      n_checks++;
      if ({out_valid6, checksum_valid6, checksum6} !== {1'b0, exp_csv, exp_cs}) begin
         n_fail++;
         $display("FAIL n6_end: vld=%b csv=%b cs=%h expected 0 %b %h", out_valid6, checksum_valid6, checksum6, exp_csv, exp_cs);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      in_blocks  = '0;
      in_valid   = 1'b0;
      out_ready  = 1'b1;
      in_blocks6 = '0;
      in_valid6  = 1'b0;
      out_ready6 = 1'b1;
      test_reset();
      test_stream();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_n6();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/matrix_collector.md
MATRIX_COLLECTOR -- requirements
Module: matrix_collector

Interface
REQ-001 SHALL have parameter N, default 4, full result matrix dimension.
REQ-002 SHALL have parameter SQRT_P, default 2, processor grid dimension; BLK = N/SQRT_P words per block side; N divisible by SQRT_P.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_blocks  input  32*N*N  flattened block results; block (bi,bj) at slot bi*SQRT_P+bj; element (k,v) of a slot at word offset k*BLK+v; word w occupies bits [32w+31:32w].
REQ-006 SHALL have port in_valid  input  1  in_blocks holds a complete result set.
REQ-007 SHALL have port in_ready  output  1  collector can accept a result set.
REQ-008 SHALL have port out_data  output  32  current matrix element.
REQ-009 SHALL have port out_row, out_col  output  $clog2(N) each  row/column of out_data.
REQ-010 SHALL have port out_valid  output  1  out_data valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-012 SHALL have port out_last  output  1  high with the element (N-1,N-1).
REQ-013 SHALL have port checksum  output  32  sum of emitted words (see Configuration).
REQ-014 SHALL have port checksum_valid  output  1  one-cycle pulse, checksum final.

Function
REQ-015 SHALL implement two states: IDLE, STREAM.
REQ-016 In IDLE, in_ready SHALL be 1 and out_valid 0.
REQ-017 On in_valid & in_ready, SHALL register all of in_blocks into an internal buffer, reset row/col counters to (0,0), and enter STREAM.
REQ-018 out_valid SHALL rise the cycle after capture (1-cycle latency), with out_data = element (0,0).
REQ-019 In STREAM, in_ready SHALL be 0; in_valid SHALL be ignored.
REQ-020 Element (r,c) SHALL be read from slot (r/BLK)*SQRT_P+(c/BLK), offset (r%BLK)*BLK+(c%BLK).
REQ-021 Emission order SHALL be row-major over the full matrix: col increments; at col = N-1, col wraps to 0 and row increments.
REQ-022 An element transfers only on out_valid & out_ready; with out_ready = 0, out_data/out_row/out_col/out_last SHALL hold stable.
REQ-023 out_last SHALL be 1 exactly while (row,col) = (N-1,N-1) and out_valid = 1.
REQ-024 On the transfer with out_last, SHALL return to IDLE; in_ready SHALL be 1 the next cycle (no back-to-back capture in that same cycle).
REQ-025 out_data SHALL be driven from the registered buffer; changes of in_blocks during STREAM SHALL not affect output.
REQ-026 Exactly N*N transfers SHALL occur per captured set.

Reset
REQ-027 While rst_n = 0: state IDLE, in_ready 0 during assertion and 1 from the first cycle after release, out_valid 0, out_last 0, out_data 0, out_row 0, out_col 0, checksum 0, checksum_valid 0.
REQ-028 Reset asserted mid-STREAM SHALL abort immediately; partial transfer is discarded and no checksum_valid is produced.

Configuration
REQ-029 Macro COLLECT_CHECKSUM_EN: when defined, checksum SHALL clear on capture, add each transferred word modulo 2^32, and checksum_valid SHALL pulse one cycle after the out_last transfer with the final sum held until next capture.
REQ-030 When COLLECT_CHECKSUM_EN is undefined, checksum and checksum_valid SHALL be constant 0 and no accumulator logic SHALL be present.

Verification
REQ-031 Defaults, in_blocks word w = w+1, out_ready = 1 -> 16 outputs in one per cycle: 1,2,5,6,3,4,7,8,9,10,13,14,11,12,15,16; out_last on 16th only.
REQ-032 Same input, out_ready toggling 1,0 -> identical sequence, outputs stable during stalls, 31 cycles from first out_valid to last transfer.
REQ-033 in_valid held high with changing in_blocks during STREAM -> in_ready = 0, output unchanged; second set captured only after out_last transfer.
REQ-034 rst_n pulsed low after 5th transfer -> out_valid 0 immediately, in_ready 1 after release, new capture restarts at (0,0).
REQ-035 COLLECT_CHECKSUM_EN defined, words 1..16 -> checksum_valid pulse with checksum = 136; undefined -> both stay 0.
REQ-036 N=6, SQRT_P=3, in_blocks all 0xFFFFFFFF -> 36 outputs 0xFFFFFFFF, out_row/out_col sweep 0..5; checksum (if enabled) = 0xFFFFFFDC.
